// File: rtl/piece_controller_pkg.sv
// Shared types, board constants and cell-placement helper for the
// active-piece controller and its shape ROM.
package piece_controller_pkg;

  localparam int X_SIZE  = 10;
  localparam int Y_SIZE  = 20;
  // Coordinates are carried mod 32 so off-board moves wrap high and fail the bounds check.
  localparam int COORD_W = $clog2((X_SIZE > Y_SIZE) ? X_SIZE : Y_SIZE);
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {P_I, P_O, P_T, P_S, P_Z, P_J, P_L} piece_t;

  typedef enum logic [2:0] {
    C_EMPTY, C_CYAN, C_YELLOW, C_PURPLE, C_GREEN, C_RED, C_BLUE, C_ORANGE
  } block_color_t;

  typedef enum logic [1:0] {S_FALL, S_LOCK, S_SPAWN, S_OVER} ctrl_state_t;

  localparam logic [15:0] I_ROT0_OFFS = 16'h159D;

  function automatic block_color_t piece_color(piece_t p);
    return block_color_t'(3'(p) + 3'd1);
  endfunction

  // offs holds 4 x {dx,dy}, cell0 in [15:12]; result is {x vector, y vector}.
  function automatic logic [39:0] place_cells(logic [15:0] offs,
                                              logic [COORD_W-1:0] ox,
                                              logic [COORD_W-1:0] oy);
    logic [39:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[39-5*k -: 5] = ox + COORD_W'(offs[15-4*k -: 2]);
      r[19-5*k -: 5] = oy + COORD_W'(offs[13-4*k -: 2]);
    end
    return r;
  endfunction

endpackage

// File: rtl/piece_controller_shape_rom.sv
// Tetromino offset ROM: 4 cells of {dx,dy} inside a 4x4 box, listed row-major
// (by dy, then dx) so cell order is stable across the design.
module piece_shape_rom
  import piece_controller_pkg::*;
(
  input  logic [2:0]  piece,
  input  logic [1:0]  rot,
  output logic [15:0] offs
);

  always_comb begin
    offs = I_ROT0_OFFS;
    case ({piece, rot})
      5'd0:  offs = I_ROT0_OFFS;
      5'd1:  offs = 16'h89AB;
      5'd2:  offs = 16'h26AE;
      5'd3:  offs = 16'h4567;
      5'd4, 5'd5, 5'd6, 5'd7: offs = 16'h4859;
      5'd8:  offs = 16'h4159;
      5'd9:  offs = 16'h4596;
      5'd10: offs = 16'h1596;
      5'd11: offs = 16'h4156;
      5'd12: offs = 16'h4815;
      5'd13: offs = 16'h459A;
      5'd14: offs = 16'h5926;
      5'd15: offs = 16'h0156;
      5'd16: offs = 16'h0459;
      5'd17: offs = 16'h8596;
      5'd18: offs = 16'h156A;
      5'd19: offs = 16'h4152;
      5'd20: offs = 16'h0159;
      5'd21: offs = 16'h4856;
      5'd22: offs = 16'h159A;
      5'd23: offs = 16'h4526;
      5'd24: offs = 16'h8159;
      5'd25: offs = 16'h456A;
      5'd26: offs = 16'h1592;
      5'd27: offs = 16'h0456;
      default: offs = I_ROT0_OFFS;
    endcase
  end

endmodule

// File: rtl/piece_controller.sv
// Falling-piece controller: holds the active tetromino, offers candidate
// positions to the board and sequences gravity, auto-repeat, lock and spawn.
module piece_controller
  import piece_controller_pkg::*;
#(
  parameter int DROP_PERIOD = 30,
  parameter int SOFT_PERIOD = 3,
  parameter int DAS_DELAY   = 10,
  parameter int DAS_RATE    = 3,
  parameter int SPAWN_X     = 3,
  parameter int SPAWN_Y     = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_down,
  input  logic        key_rot_l,
  input  logic        key_rot_r,
  input  logic [4:0]  can_move,
  output logic [19:0] x_block,
  output logic [19:0] y_block,
  output logic [19:0] save_xblock,
  output logic [19:0] save_yblock,
  output logic [19:0] x_move_left,
  output logic [19:0] y_move_left,
  output logic [19:0] x_move_right,
  output logic [19:0] y_move_right,
  output logic [19:0] x_move_down,
  output logic [19:0] y_move_down,
  output logic [19:0] x_rotate_left,
  output logic [19:0] y_rotate_left,
  output logic [19:0] x_rotate_right,
  output logic [19:0] y_rotate_right,
  output logic [2:0]  block,
  output logic        piece_locked,
  output logic        game_over
);

  localparam logic [COORD_W-1:0] SX         = COORD_W'(SPAWN_X);
  localparam logic [COORD_W-1:0] SY         = COORD_W'(SPAWN_Y);
  localparam logic [CNT_W-1:0]   GRAV_DROP  = CNT_W'(DROP_PERIOD - 1);
  localparam logic [CNT_W-1:0]   GRAV_SOFT  = CNT_W'(SOFT_PERIOD - 1);
  localparam logic [CNT_W-1:0]   DAS_MAX    = CNT_W'(DAS_DELAY);
  // Reloading below DAS_MAX makes the counter revisit DAS_MAX every DAS_RATE frames.
  localparam logic [CNT_W-1:0]   DAS_RELOAD = CNT_W'(DAS_DELAY - DAS_RATE + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  ctrl_state_t        state_q, state_d;
  piece_t             type_q, type_d, spawn_type;
  logic [1:0]         rot_q, rot_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [CNT_W-1:0]   grav_q, grav_d, das_l_q, das_l_d, das_r_q, das_r_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [4:0]         keys, keys_q, keys_d, rise;
  logic [39:0]        save_q, save_d;
  logic [15:0]        offs_cur, offs_rl, offs_rr, offs_spawn;
  logic               lock_req, drop, grav_due, rep_l, rep_r;

  assign keys       = {key_left, key_right, key_down, key_rot_l, key_rot_r};
  assign rise       = keys & ~keys_q;
  assign spawn_type = (lfsr_q[2:0] == 3'd7) ? P_I : piece_t'(lfsr_q[2:0]);
  assign grav_due   = grav_q >= (key_down ? GRAV_SOFT : GRAV_DROP);
  assign rep_l      = key_left  && (das_l_q == DAS_MAX);
  assign rep_r      = key_right && (das_r_q == DAS_MAX);

  piece_shape_rom u_rom_cur   (.piece(type_q),     .rot(rot_q),        .offs(offs_cur));
  piece_shape_rom u_rom_rl    (.piece(type_q),     .rot(rot_q - 2'd1), .offs(offs_rl));
  piece_shape_rom u_rom_rr    (.piece(type_q),     .rot(rot_q + 2'd1), .offs(offs_rr));
  piece_shape_rom u_rom_spawn (.piece(spawn_type), .rot(2'd0),         .offs(offs_spawn));

  assign {x_block, y_block}               = place_cells(offs_cur, ox_q, oy_q);
  assign {x_move_left, y_move_left}       = place_cells(offs_cur, ox_q - 5'd1, oy_q);
  assign {x_move_right, y_move_right}     = place_cells(offs_cur, ox_q + 5'd1, oy_q);
  assign {x_move_down, y_move_down}       = place_cells(offs_cur, ox_q, oy_q + 5'd1);
  assign {x_rotate_left, y_rotate_left}   = place_cells(offs_rl, ox_q, oy_q);
  assign {x_rotate_right, y_rotate_right} = place_cells(offs_rr, ox_q, oy_q);
  assign {save_xblock, save_yblock}       = save_q;
  assign block                            = piece_color(type_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FALL;
      type_q  <= P_I;
      rot_q   <= 2'd0;
      ox_q    <= SX;
      oy_q    <= SY;
      grav_q  <= '0;
      das_l_q <= '0;
      das_r_q <= '0;
      lfsr_q  <= 7'h01;
      keys_q  <= '0;
      save_q  <= place_cells(I_ROT0_OFFS, SX, SY);
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rot_q   <= rot_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      grav_q  <= grav_d;
      das_l_q <= das_l_d;
      das_r_q <= das_r_d;
      lfsr_q  <= lfsr_d;
      keys_q  <= keys_d;
      save_q  <= save_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FALL:  if (lock_req) state_d = S_LOCK;
      S_LOCK:  state_d = (oy_q == SY) ? S_OVER : S_SPAWN;
      S_SPAWN: state_d = S_FALL;
      default: state_d = S_OVER;
    endcase
  end

  always_comb begin
    piece_locked = (state_q == S_LOCK);
    game_over    = (state_q == S_OVER);
  end

  always_comb begin
    type_d   = type_q;
    rot_d    = rot_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    grav_d   = grav_q;
    das_l_d  = das_l_q;
    das_r_d  = das_r_q;
    keys_d   = keys;
    lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    save_d   = {x_block, y_block};
    lock_req = 1'b0;
    drop     = 1'b0;
    case (state_q)
      S_FALL: begin
        // Left suppresses right entirely while held; rejected requests are simply dropped.
        if (rise[0] && can_move[2])                            rot_d = rot_q + 2'd1;
        else if (rise[1] && can_move[1])                       rot_d = rot_q - 2'd1;
        else if ((rise[4] || rep_l) && can_move[4])            ox_d  = ox_q - 5'd1;
        else if (!key_left && (rise[3] || rep_r) && can_move[3]) ox_d = ox_q + 5'd1;
        else if (grav_due) begin
          if (can_move[0]) begin
            oy_d = oy_q + 5'd1;
            drop = 1'b1;
          end else begin
            lock_req = 1'b1;
          end
        end
        grav_d  = drop ? '0 : (grav_due ? grav_q : grav_q + CNT_ONE);
        das_l_d = !key_left  ? '0 : (das_l_q == DAS_MAX) ? DAS_RELOAD : das_l_q + CNT_ONE;
        das_r_d = !key_right ? '0 : (das_r_q == DAS_MAX) ? DAS_RELOAD : das_r_q + CNT_ONE;
      end
      S_SPAWN: begin
        type_d  = spawn_type;
        rot_d   = 2'd0;
        ox_d    = SX;
        oy_d    = SY;
        grav_d  = '0;
        das_l_d = '0;
        das_r_d = '0;
        // Erase vector matches the new piece so the just-locked cells survive.
        save_d  = place_cells(offs_spawn, SX, SY);
      end
      S_OVER:  save_d = save_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed plus randomized bench for piece_controller against a bitmap-based
// reference model of the falling piece.
module tb_piece_controller;

  localparam int DROP  = 4;
  localparam int SOFT  = 3;
  localparam int DAS   = 10;
  localparam int RATE  = 3;
  localparam int SPX   = 3;
  localparam int SPY   = 0;
  localparam logic [4:0] KL = 5'b10000, KR = 5'b01000, KD = 5'b00100, KRL = 5'b00010, KRR = 5'b00001;
  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [19:0] X_SPAWN = {5'd3, 5'd4, 5'd5, 5'd6};

  // 4x4 occupancy masks, bit index = dy*4 + dx; order I,O,T,S,Z,J,L x rot 0..3
  localparam logic [15:0] MASKS [0:27] = '{
    16'h00F0, 16'h4444, 16'h0F00, 16'h2222,
    16'h0066, 16'h0066, 16'h0066, 16'h0066,
    16'h0072, 16'h0262, 16'h0270, 16'h0232,
    16'h0036, 16'h0462, 16'h0360, 16'h0231,
    16'h0063, 16'h0264, 16'h0630, 16'h0132,
    16'h0071, 16'h0226, 16'h0470, 16'h0322,
    16'h0074, 16'h0622, 16'h0170, 16'h0223};

  logic Clk = 1'b0, Reset = 1'b1;
  logic key_left = 0, key_right = 0, key_down = 0, key_rot_l = 0, key_rot_r = 0;
  logic [4:0] can_move = '1;
  logic [19:0] x_block, y_block, save_xblock, save_yblock;
  logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right, x_move_down, y_move_down;
  logic [19:0] x_rotate_left, y_rotate_left, x_rotate_right, y_rotate_right;
  logic [2:0]  block;
  logic        piece_locked, game_over;

  piece_controller #(
    .DROP_PERIOD(DROP), .SOFT_PERIOD(SOFT), .DAS_DELAY(DAS), .DAS_RATE(RATE),
    .SPAWN_X(SPX), .SPAWN_Y(SPY)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rot_l(key_rot_l), .key_rot_r(key_rot_r), .can_move(can_move),
    .x_block(x_block), .y_block(y_block), .save_xblock(save_xblock), .save_yblock(save_yblock),
    .x_move_left(x_move_left), .y_move_left(y_move_left),
    .x_move_right(x_move_right), .y_move_right(y_move_right),
    .x_move_down(x_move_down), .y_move_down(y_move_down),
    .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
    .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
    .block(block), .piece_locked(piece_locked), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;

  // Model: phase 0 falling, 1 locking, 2 spawning, 3 game over
  bit          m_valid = 0;
  int          m_phase, m_type, m_rot, m_ox, m_oy, m_g, m_hl, m_hr;
  logic [4:0]  m_prev;
  logic [6:0]  m_lfsr;
  logic [39:0] m_save;

  function automatic logic [39:0] cells(int t, int r, int ox, int oy);
    logic [15:0] m;
    logic [19:0] xv, yv;
    int k;
    m = MASKS[t*4 + r];
    xv = '0; yv = '0; k = 0;
    for (int b = 0; b < 16; b++)
      if (m[b]) begin
        xv[19-5*k -: 5] = 5'((ox + b % 4) % 32);
        yv[19-5*k -: 5] = 5'((oy + b / 4) % 32);
        k++;
      end
    return {xv, yv};
  endfunction

  function automatic bit rep_due(int h);
    return (h >= DAS) && ((h - DAS) % RATE == 0);
  endfunction

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    if (m_valid) begin
      chk("cells",      {x_block, y_block},               cells(m_type, m_rot, m_ox, m_oy));
      chk("save",       {save_xblock, save_yblock},       m_save);
      chk("move_left",  {x_move_left, y_move_left},       cells(m_type, m_rot, (m_ox + 31) % 32, m_oy));
      chk("move_right", {x_move_right, y_move_right},     cells(m_type, m_rot, (m_ox + 1) % 32, m_oy));
      chk("move_down",  {x_move_down, y_move_down},       cells(m_type, m_rot, m_ox, (m_oy + 1) % 32));
      chk("rot_left",   {x_rotate_left, y_rotate_left},   cells(m_type, (m_rot + 3) % 4, m_ox, m_oy));
      chk("rot_right",  {x_rotate_right, y_rotate_right}, cells(m_type, (m_rot + 1) % 4, m_ox, m_oy));
      chk("block",      40'(block),        40'(m_type + 1)); // colours are piece index + 1
      chk("locked",     40'(piece_locked), 40'(m_phase == 1));
      chk("game_over",  40'(game_over),    40'(m_phase == 3));
    end
  endtask

  task automatic model_update(input logic [4:0] k, input logic [4:0] c, input logic r);
    logic [4:0] rise;
    bit lrep, rrep, due;
    if (r) begin
      m_valid = 1; m_phase = 0; m_type = 0; m_rot = 0; m_ox = SPX; m_oy = SPY;
      m_g = 0; m_hl = 0; m_hr = 0; m_prev = '0; m_lfsr = 7'h01;
      m_save = cells(0, 0, SPX, SPY);
    end else begin
      rise = k & ~m_prev;
      case (m_phase)
        0: begin
          m_save = cells(m_type, m_rot, m_ox, m_oy);
          lrep = k[4] && rep_due(m_hl);
          rrep = k[3] && rep_due(m_hr);
          due  = m_g >= (k[2] ? SOFT : DROP) - 1;
          if (!due) m_g++;
          if (rise[0] && c[2])                          m_rot = (m_rot + 1) % 4;
          else if (rise[1] && c[1])                     m_rot = (m_rot + 3) % 4;
          else if ((rise[4] || lrep) && c[4])           m_ox = (m_ox + 31) % 32;
          else if (!k[4] && (rise[3] || rrep) && c[3])  m_ox = (m_ox + 1) % 32;
          else if (due) begin
            if (c[0]) begin m_oy = (m_oy + 1) % 32; m_g = 0; end
            else m_phase = 1;
          end
          m_hl = k[4] ? m_hl + 1 : 0;
          m_hr = k[3] ? m_hr + 1 : 0;
        end
        1: begin
          m_save  = cells(m_type, m_rot, m_ox, m_oy);
          m_phase = (m_oy == SPY) ? 3 : 2;
        end
        2: begin
          m_type = (m_lfsr[2:0] == 3'd7) ? 0 : int'(m_lfsr[2:0]);
          m_rot = 0; m_ox = SPX; m_oy = SPY; m_g = 0; m_hl = 0; m_hr = 0;
          m_save = cells(m_type, 0, SPX, SPY);
          m_phase = 0;
        end
        default: ;
      endcase
      m_prev = k;
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end
  endtask

  task automatic step(input logic [4:0] k, input logic [4:0] c, input logic r);
    {key_left, key_right, key_down, key_rot_l, key_rot_r} = k;
    can_move = c;
    Reset    = r;
    check_all();
    @(posedge Clk);
    model_update(k, c, r);
    #1;
  endtask

  initial begin
    logic [4:0] k, c;
    int over_cnt, locked_seen;

    // Reset values, then gravity with the short drop period
    step('0, ALL, 1'b1);
    chk("rst_x", 40'(x_block), 40'(X_SPAWN));
    chk("rst_y", 40'(y_block), 40'({4{5'd1}}));
    chk("rst_save_x", 40'(save_xblock), 40'(X_SPAWN));
    chk("rst_go", 40'(game_over), 40'd0);
    repeat (4) step('0, ALL, 1'b0);
    chk("grav_y4", 40'(y_block), 40'({4{5'd2}}));
    chk("grav_save4", 40'(save_yblock), 40'({4{5'd1}}));
    repeat (4) step('0, ALL, 1'b0);
    chk("grav_y8", 40'(y_block), 40'({4{5'd3}}));

    // Single left press accepted, then one rejected
    step(KL, ALL, 1'b0);
    chk("left_x", 40'(x_block), 40'({5'd2, 5'd3, 5'd4, 5'd5}));
    chk("left_save", 40'(save_xblock), 40'(X_SPAWN));
    step('0, ALL, 1'b0);
    step(KL, 5'b01111, 1'b0);
    step('0, ALL, 1'b0);
    chk("left_blocked", 40'(x_block), 40'({5'd2, 5'd3, 5'd4, 5'd5}));

    // Held left: moves on cycles 0,10,13,16,19 -> origin 3-5 wraps to 30
    step('0, ALL, 1'b1);
    repeat (20) step(KL, ALL, 1'b0);
    chk("das_x", 40'(x_block[19:15]), 40'd30);

    // Rotation outranks a simultaneous left press
    step('0, ALL, 1'b1);
    step(KL | KRR, ALL, 1'b0);
    chk("prio_x", 40'(x_block), 40'({4{5'd5}}));
    chk("prio_y", 40'(y_block), 40'({5'd0, 5'd1, 5'd2, 5'd3}));

    // Drop to origin y 5, then lock and spawn
    step('0, ALL, 1'b1);
    repeat (20) step('0, ALL, 1'b0);
    chk("drop_y5", 40'(y_block), 40'({4{5'd6}}));
    locked_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step('0, 5'b11110, 1'b0);
      if (piece_locked) locked_seen++;
    end
    chk("lock_pulses", 40'(locked_seen), 40'd1);
    chk("lock_no_over", 40'(game_over), 40'd0);

    // Soft drop and right moves in a short directed burst
    step('0, ALL, 1'b1);
    repeat (6) step(KD | KR, ALL, 1'b0);
    step(KRL, ALL, 1'b0);
    step('0, ALL, 1'b0);

    // Game over at the spawn row; everything frozen despite keys
    step('0, ALL, 1'b1);
    repeat (6) step('0, 5'b11110, 1'b0);
    chk("over_set", 40'(game_over), 40'd1);
    for (int i = 0; i < 50; i++) step(5'($urandom), 5'($urandom), 1'b0);
    chk("over_frozen_x", 40'(x_block), 40'(X_SPAWN));
    chk("over_still", 40'(game_over), 40'd1);
    step('0, ALL, 1'b1);
    chk("over_cleared", 40'(game_over), 40'd0);

    // Randomized play with sticky keys and mostly-permissive board
    k = '0; over_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      k ^= 5'($urandom & $urandom & $urandom);
      c = 5'($urandom | $urandom | $urandom);
      c[0] = ($urandom_range(0, 5) != 0);
      over_cnt = (m_phase == 3) ? over_cnt + 1 : 0;
      step(k, c, (over_cnt > 10) || ($urandom_range(0, 400) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
